udcnt_param: RTL and testbench

Parametrised up/down counter, the next generation of the team's fixed 4-bit enable/direction counter. It adds configurable width and modulus, synchronous load, and a choice of wrap or saturate at each boundary. It also provides a terminal-count pulse, a sticky overflow flag and an optional tick prescaler. It sits beside timers and event counters in the control datapath, and any block needing a bounded, loadable count uses it.

---
 rtl/udcnt_pkg.sv | 42 ++++
 rtl/udcnt_param_if.sv | 32 +++
 rtl/udcnt_prescaler.sv | 29 ++
 rtl/udcnt_param.sv | 73 +++++++
 tb/tb_udcnt_param.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/udcnt_pkg.sv
// Shared constants and next-count function for the parametrised up/down counter.
// Arithmetic is carried in a 33-bit extended type, which covers WIDTH+1 for widths up to 32.
package udcnt_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CNT_EXT_W = 33;

  typedef logic [CNT_EXT_W-1:0] cnt_ext_t;

  typedef struct packed {
    logic     bnd;
    cnt_ext_t nxt;
  } step_t;

  function automatic step_t udcnt_step(input cnt_ext_t cnt, input logic ud,
                                       input logic sat, input cnt_ext_t mod_max);
    step_t s;
    s.bnd = 1'b0;
    s.nxt = cnt;
    if (ud == DIR_UP) begin
      if (cnt >= mod_max) begin
        s.bnd = 1'b1;
        s.nxt = (sat == MODE_SAT) ? mod_max : '0;
      end else begin
        s.nxt = cnt + cnt_ext_t'(1);
      end
    end else begin
      if (cnt == '0) begin
        s.bnd = 1'b1;
        s.nxt = (sat == MODE_SAT) ? '0 : mod_max;
      end else begin
        s.nxt = cnt - cnt_ext_t'(1);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/udcnt_param_if.sv
// Control/status bundle of the up/down counter.
// The prescale field exists only when UDCNT_PRESCALE_EN is defined.
interface udcnt_param_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic             en;
  logic             ud;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
`ifdef UDCNT_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;
`endif
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

`ifdef UDCNT_PRESCALE_EN
  modport master (output en, ud, sat, load, load_val, ovf_clr, prescale,
                  input  count, tc, ovf);
  modport slave  (input  en, ud, sat, load, load_val, ovf_clr, prescale,
                  output count, tc, ovf);
`else
  modport master (output en, ud, sat, load, load_val, ovf_clr,
                  input  count, tc, ovf);
  modport slave  (input  en, ud, sat, load, load_val, ovf_clr,
                  output count, tc, ovf);
`endif

endinterface

// File: rtl/udcnt_prescaler.sv
// Tick divider: tick fires on every (prescale+1)-th enabled cycle.
// Used by udcnt_param only when UDCNT_PRESCALE_EN is defined.
module udcnt_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_phase;
  logic                  w_wrap;

  // >= rather than == so a divisor lowered mid-phase still wraps promptly
  assign w_wrap = (r_phase >= prescale);
  assign tick   = en && w_wrap;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= w_wrap ? '0 : r_phase + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/udcnt_param.sv
// Parametrised up/down counter with load, wrap/saturate, terminal-count pulse and sticky overflow.
// Optional tick prescaler enabled by defining UDCNT_PRESCALE_EN.
module udcnt_param
  import udcnt_pkg::*;
#(
  parameter int              WIDTH      = 8,
  parameter longint unsigned MOD_MAX    = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  udcnt_param_if.slave  bus
);

  localparam cnt_ext_t             MAX_EXT = cnt_ext_t'(MOD_MAX);
  localparam logic [WIDTH-1:0]     MAX_W   = WIDTH'(MOD_MAX);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             w_tick;
  logic             w_bnd_step;
  logic [WIDTH-1:0] w_step_cnt;
  logic [WIDTH-1:0] w_load_cnt;
  step_t            w_step;

`ifdef UDCNT_PRESCALE_EN
  udcnt_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .restart  (bus.load),
    .prescale (bus.prescale),
    .tick     (w_tick)
  );
`else
  assign w_tick = bus.en;
`endif

  assign w_step     = udcnt_step(cnt_ext_t'(r_count), bus.ud, bus.sat, MAX_EXT);
  assign w_step_cnt = WIDTH'(w_step.nxt);
  assign w_bnd_step = !bus.load && w_tick && w_step.bnd;
  // Out-of-range load values clamp so count can never leave 0..MOD_MAX
  assign w_load_cnt = (cnt_ext_t'(bus.load_val) > MAX_EXT) ? MAX_W : bus.load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.load) begin
        r_count <= w_load_cnt;
      end else if (w_tick) begin
        r_count <= w_step_cnt;
      end
      r_tc <= w_bnd_step;
      // A boundary step in the same cycle as ovf_clr keeps the flag set
      if (w_bnd_step) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_udcnt_param.sv
// Bench for udcnt_param (WIDTH=4, MOD_MAX=9): directed vector table, corner sequences,
// and randomized stimulus against a behavioural model; prescaler checks when UDCNT_PRESCALE_EN is defined.
module tb_udcnt_param;

  localparam int W    = 4;
  localparam int MAXV = 9;
  localparam int PW   = 4;

  logic clk;
  logic rst;

  udcnt_param_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  udcnt_param #(
    .WIDTH      (W),
    .MOD_MAX    (MAXV),
    .PRESCALE_W (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_cnt = 0;
  int m_tc  = 0;
  int m_ovf = 0;
  int m_ps  = 0;

  typedef struct {
    int r, en, ud, sat, ld, lv, clr;
    int e_cnt, e_tc, e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int r, input int en, input int ud, input int sat,
                       input int ld, input int lv, input int clr);
    rst          = (r != 0);
    bus.en       = (en != 0);
    bus.ud       = (ud != 0);
    bus.sat      = (sat != 0);
    bus.load     = (ld != 0);
    bus.load_val = W'(lv);
    bus.ovf_clr  = (clr != 0);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int c, input int t, input int o);
    check({tag, ".count"}, int'(bus.count), c);
    check({tag, ".tc"},    int'(bus.tc),    t);
    check({tag, ".ovf"},   int'(bus.ovf),   o);
  endtask

  // Reference model: next state from the counter's rules, with plain integer arithmetic
  task automatic model(input int r, input int en, input int ud, input int sat,
                       input int ld, input int lv, input int clr, input int ps);
    int nxt;
    int tick;
    int bnd;
    bnd = 0;
    if (r != 0) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_ps = 0;
    end else if (ld != 0) begin
      m_cnt = (lv > MAXV) ? MAXV : lv;
      m_tc  = 0;
      m_ps  = 0;
      if (clr != 0) m_ovf = 0;
    end else begin
      tick = 0;
      if (en != 0) begin
        if (m_ps >= ps) begin tick = 1; m_ps = 0; end
        else m_ps = m_ps + 1;
      end
      if (tick != 0) begin
        nxt = (ud != 0) ? m_cnt + 1 : m_cnt - 1;
        if (nxt < 0 || nxt > MAXV) begin
          bnd = 1;
          nxt = (sat != 0) ? m_cnt : (nxt + MAXV + 1) % (MAXV + 1);
        end
        m_cnt = nxt;
      end
      m_tc = bnd;
      if (bnd != 0) m_ovf = 1;
      else if (clr != 0) m_ovf = 0;
    end
  endtask

  initial begin
    int sat_seq[3];
    int r, en, ud, sat, ld, lv, clr, ps;

    drive(1, 0, 0, 0, 0, 0, 0);
`ifdef UDCNT_PRESCALE_EN
    bus.prescale = '0;
`endif

    // rst en ud sat ld lv clr | count tc ovf
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,  0, 0, 0});
    for (int i = 1; i <= 12; i++)
      vecs.push_back('{0, 1, 1, 0, 0, 0, 0,  i % 10, (i == 10) ? 1 : 0, (i >= 10) ? 1 : 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0,  2, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,  0, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 1, 2, 0,  2, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 0,  1, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 0,  0, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 0,  0, 1, 1});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 1,  0, 1, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 1,  0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 1, 15, 0, 9, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 0,  0, 1, 1});
    vecs.push_back('{0, 1, 1, 0, 1, 5, 0,  5, 0, 1});
    vecs.push_back('{1, 1, 1, 0, 1, 7, 0,  0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 1, 9, 0,  9, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0,  8, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].en, vecs[i].ud, vecs[i].sat, vecs[i].ld, vecs[i].lv, vecs[i].clr);
      tick_clk();
      check_outs($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_ovf);
    end

    // Held at MOD_MAX while saturating upward: tc on every cycle
    drive(1, 0, 0, 0, 0, 0, 0); tick_clk();
    drive(0, 0, 1, 1, 1, 9, 0); tick_clk();
    check_outs("satld", 9, 0, 0);
    sat_seq = '{1, 1, 1};
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 0, 0, 0);
      tick_clk();
      check_outs($sformatf("sathold%0d", i), 9, sat_seq[i], 1);
    end

`ifdef UDCNT_PRESCALE_EN
    begin
      int exp_c[13];
      int ens[13];
      exp_c = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3, 3};
      ens   = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 1};
      drive(1, 0, 0, 0, 0, 0, 0); bus.prescale = PW'(2); tick_clk();
      for (int i = 0; i < 13; i++) begin
        drive(0, ens[i], 1, 0, 0, 0, 0);
        tick_clk();
        check($sformatf("ps%0d.count", i), int'(bus.count), exp_c[i]);
      end
      // load restarts the phase: two quiet enabled cycles before the next step
      drive(0, 1, 1, 0, 1, 4, 0); tick_clk();
      check("psld.count", int'(bus.count), 4);
      for (int i = 0; i < 3; i++) begin
        drive(0, 1, 1, 0, 0, 0, 0);
        tick_clk();
        check($sformatf("psrs%0d.count", i), int'(bus.count), (i == 2) ? 5 : 4);
      end
    end
`endif

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      r   = (i == 0 || $urandom_range(0, 39) == 0) ? 1 : 0;
      en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ud  = int'($urandom_range(0, 1));
      sat = int'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      lv  = int'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0) ? 1 : 0;
      ps  = 0;
`ifdef UDCNT_PRESCALE_EN
      ps = int'($urandom_range(0, 3));
      bus.prescale = PW'(ps);
`endif
      drive(r, en, ud, sat, ld, lv, clr);
      model(r, en, ud, sat, ld, lv, clr, ps);
      tick_clk();
      check_outs($sformatf("rnd%0d", i), m_cnt, m_tc, m_ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
